// File: rtl/im_stream_loader.sv
// Byte-stream program loader for the instruction memory: LEN, N x {LO,HI}, optional CSUM.
// Define IM_LOADER_CSUM_EN to require and verify a trailing 8-bit checksum byte.
module im_stream_loader #(
  parameter int INSTR_W = 15,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               im_we_o,
  output logic [ADDR_W-1:0]  im_addr_o,
  output logic [INSTR_W-1:0] im_wdata_o,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               error_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
`ifdef IM_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
`endif
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // HI byte bits that fall outside the instruction word
  localparam logic [7:0] HI_MASK = 8'(8'hFF << (INSTR_W - 8));

  logic [2:0]         state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         lo_q, lo_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               rdy_q, we_q, hold_q, done_q, err_q;
  logic               xfer;
`ifdef IM_LOADER_CSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  assign xfer = in_valid_i & rdy_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IM_LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN;
          idx_d   = '0;
`ifdef IM_LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_d = in_data_i;
`ifdef IM_LOADER_CSUM_EN
          sum_d = in_data_i;
`endif
          if (in_data_i == 8'd0 || {24'd0, in_data_i} > (32'd1 << ADDR_W))
            state_d = S_ERR;
          else
            state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = in_data_i;
`ifdef IM_LOADER_CSUM_EN
          sum_d   = sum_q + in_data_i;
`endif
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
`ifdef IM_LOADER_CSUM_EN
          sum_d = sum_q + in_data_i;
`endif
          if (|(in_data_i & HI_MASK)) begin
            state_d = S_ERR;
          end else begin
            // Write port is loaded here so it is valid throughout WRITE
            state_d = S_WRITE;
            addr_d  = idx_q;
            wdata_d = {in_data_i[INSTR_W-9:0], lo_q};
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (32'(idx_q) + 32'd1 == 32'(len_q))
`ifdef IM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        else
          state_d = S_LO;
      end
`ifdef IM_LOADER_CSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (in_data_i == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // Flags are registered decodes of the next state
      rdy_q   <= (state_d == S_LEN) || (state_d == S_LO) || (state_d == S_HI)
`ifdef IM_LOADER_CSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
      we_q    <= (state_d == S_WRITE);
      hold_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
`ifdef IM_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready_o = rdy_q;
  assign im_we_o    = we_q;
  assign im_addr_o  = addr_q;
  assign im_wdata_o = wdata_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign error_o    = err_q;

endmodule
